sensor_scan_ctrl: RTL and testbench
===================================

# sensor_scan_ctrl

Measurement controller for the ring-oscillator sensor array. It drives the shared sensor enable for a fixed measurement window, then lets the sensor counters settle. It then reads each sensor's frequency count one per cycle and accumulates them into an overflow-free sum. The sum is delivered to the downstream consumer over a valid/ready handshake. It sits between the ro_sensor instances, which it initiates, and the readout/telemetry logic.

## Interface
Parameters:
- NUM_SENSOR, 20, number of ro_sensor instances scanned.
- WIDTH, 16, width of each sensor's freq count.
- WINDOW_CYCLES, 1024, clk cycles sensor_en is held high per measurement (≥1).
- SETTLE_CYCLES, 4, clk cycles waited after sensor_en falls before reading (≥1).

Ports:
- clk  in  1  system clock, also the sensors' ref_clk.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- sensor_en  out  NUM_SENSOR  enable to each ro_sensor; all bits identical, registered.
- freq  in  NUM_SENSOR*WIDTH  packed sensor counts, sensor i at bits [i*WIDTH +: WIDTH].
- sum  out  SUM_W  accumulated count, where SUM_W = WIDTH + $clog2(NUM_SENSOR).
- sum_valid  out  1  sum is valid.
- sum_ready  in  1  consumer accepts sum.

## Operation
- Sensor contract: each ro_sensor clears its counter on a rising en and holds its count while en is low.
- FSM states and transitions:
  - IDLE → ENABLE on start.
  - ENABLE → SETTLE after WINDOW_CYCLES.
  - SETTLE → ACCUM after SETTLE_CYCLES.
  - ACCUM → DONE after NUM_SENSOR reads.
  - DONE → IDLE on sum_valid && sum_ready.
- IDLE: sensor_en=0 and sum_valid=0. The accumulator is cleared on entry to ENABLE.
- ENABLE: sensor_en all ones. A down-counter loaded with WINDOW_CYCLES-1 runs to 0.
- SETTLE: sensor_en=0. The counter runs from SETTLE_CYCLES-1 to 0.
- ACCUM: an index from 0 to NUM_SENSOR-1 selects freq[idx]. Each cycle, acc <= acc + zero-extended freq[idx].
- DONE: sum_valid=1 and sum=acc, both held stable until the handshake completes.
- Arithmetic: all adds are unsigned at SUM_W, so overflow cannot occur. All-ones inputs sum to NUM_SENSOR*(2^WIDTH-1).
- start outside IDLE is ignored, with no queuing. start in the handshake cycle is also ignored.
- Reset values: busy=0, sensor_en=0, sum=0, sum_valid=0, state=IDLE, all counters 0.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous reset). sensor_en falls without waiting for a clock edge, and any partial sum is discarded.

## Timing
- Let start be sampled high at edge k.
- sensor_en is high after edges k through k+WINDOW_CYCLES-1, i.e. exactly WINDOW_CYCLES cycles.
- ACCUM begins at edge k+WINDOW_CYCLES+SETTLE_CYCLES.
- sum_valid rises after edge k+WINDOW_CYCLES+SETTLE_CYCLES+NUM_SENSOR.
- The handshake completes on the first edge where sum_valid && sum_ready. sum_valid is low after that edge.
- freq is sampled only during ACCUM and is required stable there, which the sensor contract guarantees.
- busy is combinational from the state register.

## Configuration
- SENSOR_MINMAX_EN:
  - When defined, adds outputs min_freq and max_freq (out, WIDTH each). These track the minimum and maximum freq[idx] during ACCUM, are valid with sum_valid, and reset to 0.
  - When undefined, the ports and logic are absent and the rest of the behaviour is unchanged.

## Structure
- Shared package sensor_pkg:
  - scan_state_t enum (IDLE, ENABLE, SETTLE, ACCUM, DONE).
  - function sum_width(width, n) returning width+$clog2(n).
  - Default constants for NUM_SENSOR, WIDTH and WINDOW_CYCLES.
- Sub-module sensor_window_timer: a loadable down-counter with a load input, a value, and a zero flag. It is reused for both the ENABLE and SETTLE phases.

## Test plan
Unless stated otherwise, the bench uses NUM_SENSOR=4, WIDTH=16, WINDOW_CYCLES=8, SETTLE_CYCLES=2, with sum_ready tied high.
- Basic measurement: freq={400,300,200,100}, start pulsed at edge 0.
  - sensor_en high for exactly 8 cycles.
  - sum_valid rises after edge 14 with sum=1000.
  - busy low after the handshake.
- Saturation inputs: all freq=16'hFFFF → sum=18'h3FFFC. SUM_W=18, with no wrap.
- Backpressure: sum_ready held low for 5 cycles after sum_valid.
  - sum and sum_valid stay stable.
  - The handshake occurs on the first edge with ready high, and state returns to IDLE.
- Start while busy: start pulsed during ENABLE and during DONE.
  - Both are ignored: exactly one result is produced, and the window is not extended.
- Reset mid-window: rst_n asserted at cycle 3 of ENABLE.
  - sensor_en drops to 0 before the next clk edge, with sum_valid=0 and busy=0.
  - A subsequent start yields a correct sum.
- With SENSOR_MINMAX_EN defined and freq={400,300,200,100}: min_freq=100 and max_freq=400 together with sum=1000.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared definitions for the ring-oscillator sensor scan controller.
//   scan_state_t : controller FSM states
//   sum_width()  : accumulator width able to hold n counts of `width` bits without overflow
//   DEF_*        : default sizing used by sensor_scan_ctrl
package sensor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENABLE = 3'd1,
    SETTLE = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4
  } scan_state_t;

  localparam int DEF_NUM_SENSOR    = 20;
  localparam int DEF_WIDTH         = 16;
  localparam int DEF_WINDOW_CYCLES = 1024;
  localparam int DEF_SETTLE_CYCLES = 4;

  function automatic int sum_width(input int width, input int n);
    return width + $clog2(n);
  endfunction

endpackage

// File: rtl/sensor_window_timer.sv
// Loadable down-counter shared by the ENABLE and SETTLE phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   value      : current count; decrements each cycle until it reaches 0, then holds
//   zero       : value == 0
module sensor_window_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          zero
);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - TW'(1);
    end
  end

  assign value = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Measurement controller for the ring-oscillator sensor array.
// Holds sensor_en high for WINDOW_CYCLES, waits SETTLE_CYCLES, then reads one
// sensor count per cycle into an overflow-free sum that is offered on a
// valid/ready handshake.
// Ports:
//   clk, rst_n          : clock (also sensor ref_clk), asynchronous active-low reset
//   start               : measurement request, honoured only in IDLE
//   busy                : state != IDLE
//   sensor_en           : registered enable broadcast to every sensor
//   freq                : packed sensor counts, sensor i at [i*WIDTH +: WIDTH]
//   sum, sum_valid      : accumulated result and its valid flag
//   sum_ready           : consumer accepts the result
//   min_freq, max_freq  : only with SENSOR_MINMAX_EN defined; extremes of the scanned counts
// Optional feature macro: SENSOR_MINMAX_EN
module sensor_scan_ctrl
  import sensor_pkg::*;
#(
  parameter int NUM_SENSOR    = DEF_NUM_SENSOR,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int SUM_W        = sum_width(WIDTH, NUM_SENSOR)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic [NUM_SENSOR-1:0]       sensor_en,
  input  logic [NUM_SENSOR*WIDTH-1:0] freq,
  output logic [SUM_W-1:0]            sum,
  output logic                        sum_valid,
  input  logic                        sum_ready
`ifdef SENSOR_MINMAX_EN
  ,
  output logic [WIDTH-1:0]            min_freq,
  output logic [WIDTH-1:0]            max_freq
`endif
);

  localparam int TMAX    = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IDX_W   = (NUM_SENSOR > 1) ? $clog2(NUM_SENSOR) : 1;

  localparam logic [TIMER_W-1:0] WIN_LOAD    = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_SENSOR - 1);

  scan_state_t        state_reg, state_next;
  logic               en_reg;
  logic [SUM_W-1:0]   acc_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;
  logic [WIDTH-1:0]   freq_sel;

  // Phase transitions key off the zero flag; the raw count is not needed here.
  logic unused_timer_value;
  assign unused_timer_value = ^timer_value;

  sensor_window_timer #(.TW(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value),
    .zero     (timer_zero)
  );

  assign freq_sel = freq[idx_reg*WIDTH +: WIDTH];

  // Next-state logic; the timer is loaded on the transitions into ENABLE and SETTLE
  // so each phase lasts exactly load+1 cycles.
  always_comb begin
    state_next     = state_reg;
    timer_load     = 1'b0;
    timer_load_val = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = ENABLE;
          timer_load     = 1'b1;
          timer_load_val = WIN_LOAD;
        end
      end
      ENABLE: begin
        if (timer_zero) begin
          state_next     = SETTLE;
          timer_load     = 1'b1;
          timer_load_val = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (timer_zero) state_next = ACCUM;
      end
      ACCUM: begin
        if (idx_reg == IDX_LAST) state_next = DONE;
      end
      DONE: begin
        if (sum_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      en_reg    <= 1'b0;
      acc_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Registered from the next state so the enable tracks ENABLE exactly.
      en_reg    <= (state_next == ENABLE);
      if (state_reg == IDLE && start) begin
        acc_reg <= '0;
      end else if (state_reg == ACCUM) begin
        acc_reg <= acc_reg + SUM_W'(freq_sel);
      end
      if (state_reg == ACCUM && idx_reg != IDX_LAST) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end else begin
        idx_reg <= '0;
      end
    end
  end

`ifdef SENSOR_MINMAX_EN
  logic [WIDTH-1:0] min_reg, max_reg;

  // The first read of a scan seeds both extremes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (state_reg == ACCUM) begin
      if (idx_reg == '0 || freq_sel < min_reg) min_reg <= freq_sel;
      if (idx_reg == '0 || freq_sel > max_reg) max_reg <= freq_sel;
    end
  end

  assign min_freq = min_reg;
  assign max_freq = max_reg;
`endif

  assign busy      = (state_reg != IDLE);
  assign sensor_en = {NUM_SENSOR{en_reg}};
  assign sum       = acc_reg;
  assign sum_valid = (state_reg == DONE);

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Self-checking bench for sensor_scan_ctrl (NUM_SENSOR=4, WIDTH=16, WINDOW=8, SETTLE=2).
// Expected sums are computed from the stimulus and queued when start is driven;
// they are popped and compared when a handshake is observed.
module tb_sensor_scan_ctrl;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [N-1:0]  sensor_en;
  logic [N*W-1:0] freq = '0;
  logic [SW-1:0] sum;
  logic          sum_valid;
  logic          sum_ready = 1'b1;
`ifdef SENSOR_MINMAX_EN
  logic [W-1:0]  min_freq, max_freq;
`endif

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] got_q[$];

  // Observations of the most recent measure() run
  int obs_en_cycles, obs_en_first, obs_en_last, obs_valid_edge, obs_done_edge, obs_results;
  bit obs_stable, obs_busy_after, obs_valid_after;
`ifdef SENSOR_MINMAX_EN
  logic [W-1:0] obs_min, obs_max;
`endif

  sensor_scan_ctrl #(
    .NUM_SENSOR(N), .WIDTH(W), .WINDOW_CYCLES(8), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .sensor_en(sensor_en),
    .freq(freq), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready)
`ifdef SENSOR_MINMAX_EN
    , .min_freq(min_freq), .max_freq(max_freq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] model_sum(input logic [N*W-1:0] f);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(f[i*W +: W]);
    return SW'(s);
  endfunction

  // Runs one measurement: start at edge 0, observes after every edge.
  // ready_low: cycles sum_ready is held low once sum_valid is seen.
  // poke1/poke2: after the observation at that edge, start is raised for one cycle.
  task automatic measure(input logic [N*W-1:0] f, input int ready_low, input int poke1, input int poke2);
    int e;
    bit hs_pending;
    logic [SW-1:0] hs_sum;
    obs_en_cycles = 0; obs_en_first = -1; obs_en_last = -1;
    obs_valid_edge = -1; obs_done_edge = -1; obs_results = 0;
    obs_stable = 1'b1; obs_busy_after = 1'b1; obs_valid_after = 1'b1;
    hs_pending = 1'b0; hs_sum = '0;
    freq = f;
    sum_ready = (ready_low == 0);
    exp_q.push_back(model_sum(f));
    start = 1'b1;
    tick();
    e = 0;
    while (e < 100) begin
      if (&sensor_en) begin
        obs_en_cycles++;
        if (obs_en_first < 0) obs_en_first = e;
        obs_en_last = e;
      end
      if (sum_valid && obs_valid_edge < 0) begin
        obs_valid_edge = e;
        hs_sum = sum;
`ifdef SENSOR_MINMAX_EN
        obs_min = min_freq;
        obs_max = max_freq;
`endif
      end else if (obs_valid_edge >= 0 && obs_done_edge < 0 && (!sum_valid || sum !== hs_sum)) begin
        obs_stable = 1'b0;
      end
      if (e == obs_done_edge) begin
        obs_busy_after = busy;
        obs_valid_after = sum_valid;
      end
      start = (e == poke1 || e == poke2);
      if (ready_low > 0) sum_ready = (obs_valid_edge >= 0 && e - obs_valid_edge >= ready_low);
      hs_pending = sum_valid && sum_ready;
      if (hs_pending) hs_sum = sum;
      tick();
      e++;
      if (hs_pending) begin
        obs_results++;
        got_q.push_back(hs_sum);
        $display("result: sum=%0d accepted at edge %0d", hs_sum, e);
        if (obs_done_edge < 0) obs_done_edge = e;
      end
      if (obs_done_edge >= 0 && e > obs_done_edge + 20) break;
    end
    start = 1'b0;
    sum_ready = 1'b1;
  endtask

  // Pops one expected/actual pair and compares them.
  task automatic test_scoreboard_pop(input string name);
    logic [SW-1:0] exp_v, got_v;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    got_v = (got_q.size() > 0) ? got_q.pop_front() : 'x;
    check_cnt++;
    if (got_v !== exp_v) $display("FAIL %s_sum: got %0h want %0h", name, got_v, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (sensor_en !== '0) $display("FAIL reset_sensor_en: got %b want 0", sensor_en); else pass_cnt++;
    check_cnt++; if (sum_valid !== 1'b0) $display("FAIL reset_sum_valid: got %b want 0", sum_valid); else pass_cnt++;
    check_cnt++; if (sum !== '0) $display("FAIL reset_sum: got %0h want 0", sum); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    measure({16'd400, 16'd300, 16'd200, 16'd100}, 0, -1, -1);
    check_cnt++; if (obs_en_cycles != 8) $display("FAIL basic_en_cycles: got %0d want 8", obs_en_cycles); else pass_cnt++;
    check_cnt++; if (obs_en_first != 0) $display("FAIL basic_en_first: got %0d want 0", obs_en_first); else pass_cnt++;
    check_cnt++; if (obs_en_last != 7) $display("FAIL basic_en_last: got %0d want 7", obs_en_last); else pass_cnt++;
    check_cnt++; if (obs_valid_edge != 14) $display("FAIL basic_valid_edge: got %0d want 14", obs_valid_edge); else pass_cnt++;
    check_cnt++; if (obs_done_edge != 15) $display("FAIL basic_done_edge: got %0d want 15", obs_done_edge); else pass_cnt++;
    check_cnt++; if (obs_busy_after !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", obs_busy_after); else pass_cnt++;
    check_cnt++; if (obs_valid_after !== 1'b0) $display("FAIL basic_valid_after: got %b want 0", obs_valid_after); else pass_cnt++;
    test_scoreboard_pop("basic");
`ifdef SENSOR_MINMAX_EN
    check_cnt++; if (obs_min !== 16'd100) $display("FAIL minmax_min: got %0d want 100", obs_min); else pass_cnt++;
    check_cnt++; if (obs_max !== 16'd400) $display("FAIL minmax_max: got %0d want 400", obs_max); else pass_cnt++;
`endif
  endtask

  task automatic test_saturation();
    measure({4{16'hFFFF}}, 0, -1, -1);
    check_cnt++; if (obs_valid_edge != 14) $display("FAIL sat_valid_edge: got %0d want 14", obs_valid_edge); else pass_cnt++;
    test_scoreboard_pop("sat");
  endtask

  task automatic test_backpressure();
    measure({16'd7, 16'd1234, 16'd50000, 16'd9}, 5, -1, -1);
    check_cnt++; if (obs_stable !== 1'b1) $display("FAIL bp_stable: got %b want 1", obs_stable); else pass_cnt++;
    check_cnt++; if (obs_done_edge != 20) $display("FAIL bp_done_edge: got %0d want 20", obs_done_edge); else pass_cnt++;
    check_cnt++; if (obs_busy_after !== 1'b0) $display("FAIL bp_busy_after: got %b want 0", obs_busy_after); else pass_cnt++;
    test_scoreboard_pop("bp");
  endtask

  task automatic test_start_while_busy();
    measure({16'd1, 16'd2, 16'd3, 16'd4}, 0, 3, 14);
    check_cnt++; if (obs_results != 1) $display("FAIL busy_results: got %0d want 1", obs_results); else pass_cnt++;
    check_cnt++; if (obs_en_cycles != 8) $display("FAIL busy_en_cycles: got %0d want 8", obs_en_cycles); else pass_cnt++;
    check_cnt++; if (obs_en_last != 7) $display("FAIL busy_en_last: got %0d want 7", obs_en_last); else pass_cnt++;
    check_cnt++; if (obs_busy_after !== 1'b0) $display("FAIL busy_busy_after: got %b want 0", obs_busy_after); else pass_cnt++;
    test_scoreboard_pop("busy");
    while (got_q.size() > 0) void'(got_q.pop_front());
  endtask

  task automatic test_reset_mid_window();
    freq = {16'd500, 16'd500, 16'd500, 16'd500};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check_cnt++; if (sensor_en !== '0) $display("FAIL rstmid_sensor_en: got %b want 0", sensor_en); else pass_cnt++;
    check_cnt++; if (sum_valid !== 1'b0) $display("FAIL rstmid_sum_valid: got %b want 0", sum_valid); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    measure({16'd40, 16'd30, 16'd20, 16'd10}, 0, -1, -1);
    check_cnt++; if (obs_valid_edge != 14) $display("FAIL rstmid_valid_edge: got %0d want 14", obs_valid_edge); else pass_cnt++;
    test_scoreboard_pop("rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
